mem_arbiter: RTL and testbench

//  Shares one single-ported word memory between two requesters: port 0 (instruction fetch), port 1 (load/store).
//  One transaction in flight; round-robin on simultaneous requests; valid/ready on request and response sides.

---
 rtl/mem_arbiter_if.sv | 33 +++
 rtl/mem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (fetch, load/store), the arbiter and
// the shared single-ported memory.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [1:0]                 req_valid;
  logic [1:0]                 req_ready;
  logic [1:0]                 req_we;
  logic [1:0][ADDR_WIDTH-1:0] req_addr;
  logic [1:0][DATA_WIDTH-1:0] req_wdata;
  logic [1:0]                 rsp_valid;
  logic [1:0]                 rsp_ready;
  logic [DATA_WIDTH-1:0]      rsp_rdata;
  logic                       rsp_err;
  logic                       mem_en;
  logic                       mem_we;
  logic [ADDR_WIDTH-1:0]      mem_addr;
  logic [DATA_WIDTH-1:0]      mem_wdata;
  logic [DATA_WIDTH-1:0]      mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of one single-ported word memory;
// one transaction in flight, misaligned requests answered with an error.
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [3:0]            LAT_C     = 4'(MEM_LATENCY);
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};

  state_t                state_r;
  state_t                state_next_s;
  logic                  last_grant_r;
  logic                  owner_r;
  logic                  we_r;
  logic                  err_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic [3:0]            cnt_r;

  logic [1:0]            grant_s;
  logic                  grant_port_s;
  logic [1:0]            req_ready_s;
  logic                  handshake_s;
  logic                  misaligned_s;
  logic                  cnt_last_s;
  logic                  rsp_done_s;
  logic                  mem_en_s;
  logic [1:0]            rsp_valid_s;

  // Round robin: a lone requester wins; on a tie the port not served last wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] valid, input logic last);
    logic [1:0] pick;
    case (valid)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
    return pick;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return (low_bits != 2'b00);
  endfunction

  // Request-side decode: grant, ready (held low while in reset), handshake.
  always_comb begin
    grant_s      = rr_pick(bus.req_valid, last_grant_r);
    grant_port_s = grant_s[1];
    if ((state_r == ST_IDLE) && reset) begin
      req_ready_s = grant_s;
    end else begin
      req_ready_s = 2'b00;
    end
    handshake_s  = |(bus.req_valid & req_ready_s);
    misaligned_s = is_misaligned(bus.req_addr[grant_port_s][1:0]);
    cnt_last_s   = (cnt_r == 4'd1);
    rsp_done_s   = bus.rsp_ready[owner_r];
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (handshake_s) begin
          if (misaligned_s) begin
            state_next_s = ST_RESP;
          end else begin
            state_next_s = ST_ISSUE;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_next_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_last_s) begin
          state_next_s = ST_RESP;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (rsp_done_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RESP;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Transaction latches, latency counter and captured response data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_r <= 1'b1;
      owner_r      <= 1'b0;
      we_r         <= 1'b0;
      err_r        <= 1'b0;
      addr_r       <= ADDR_ZERO;
      wdata_r      <= DATA_ZERO;
      rdata_r      <= DATA_ZERO;
      cnt_r        <= 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (handshake_s) begin
            owner_r      <= grant_port_s;
            last_grant_r <= grant_port_s;
            we_r         <= bus.req_we[grant_port_s];
            addr_r       <= bus.req_addr[grant_port_s];
            wdata_r      <= bus.req_wdata[grant_port_s];
            err_r        <= misaligned_s;
            rdata_r      <= DATA_ZERO;
          end
        end
        ST_ISSUE: begin
          cnt_r <= LAT_C;
        end
        ST_WAIT: begin
          cnt_r <= cnt_r - 4'd1;
          // Memory data is valid in the MEM_LATENCY-th cycle after the strobe.
          if (cnt_last_s) begin
            rdata_r <= we_r ? DATA_ZERO : bus.mem_rdata;
          end
        end
        ST_RESP: begin
          cnt_r <= 4'd0;
        end
        default: begin
          cnt_r <= 4'd0;
        end
      endcase
    end
  end

  // Output decode from the state register.
  always_comb begin
    mem_en_s = (state_r == ST_ISSUE);
    if (state_r == ST_RESP) begin
      rsp_valid_s = owner_r ? 2'b10 : 2'b01;
    end else begin
      rsp_valid_s = 2'b00;
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = rsp_valid_s;
  assign bus.rsp_rdata = rdata_r;
  assign bus.rsp_err   = err_r;
  assign bus.mem_en    = mem_en_s;
  assign bus.mem_we    = we_r;
  assign bus.mem_addr  = addr_r;
  assign bus.mem_wdata = wdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a transaction-level model.
module tb_mem_arbiter;
  localparam int LAT = 2;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem_store [logic [31:0]];
  logic [31:0] ref_mem   [logic [31:0]];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] store_rd(input logic [31:0] a);
    return mem_store.exists(a) ? mem_store[a] : init_val(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory: data for a read appears only in the LAT-th cycle after the strobe.
  int          rcyc;
  int          rd_due;
  logic [31:0] rd_data;
  initial begin
    rcyc   = 0;
    rd_due = -1;
    rd_data = 32'h0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      rcyc++;
      if (bus.mem_en) begin
        if (bus.mem_we) begin
          mem_store[bus.mem_addr] = bus.mem_wdata;
        end else begin
          rd_due  = rcyc + LAT;
          rd_data = store_rd(bus.mem_addr);
        end
      end
      bus.mem_rdata = (rcyc == rd_due) ? rd_data : $urandom();
    end
  end

  // Transaction-level reference model.
  int          mc;
  bit          have_txn;
  int          t_acc;
  int          t_rs;
  bit          t_owner;
  bit          t_we;
  bit          t_err;
  logic [31:0] t_addr;
  logic [31:0] t_wdata;
  logic [31:0] t_rdata;
  bit          last_g;
  bit          lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  task automatic model_step();
    logic [1:0] g;
    logic [1:0] exp_rv;
    bit         p;
    if (!reset) begin
      check("rst_req_ready", bus.req_ready, 0);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_rsp_rdata", bus.rsp_rdata, 0);
      check("rst_rsp_err", bus.rsp_err, 0);
      check("rst_mem_en", bus.mem_en, 0);
      check("rst_mem_we", bus.mem_we, 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_mem_wdata", bus.mem_wdata, 0);
      have_txn  = 1'b0;
      last_g    = 1'b1;
      lat_we    = 1'b0;
      lat_addr  = 32'h0;
      lat_wdata = 32'h0;
    end else begin
      mc++;
      if (have_txn) g = 2'b00;
      else if (bus.req_valid == 2'b11) g = last_g ? 2'b01 : 2'b10;
      else g = bus.req_valid;
      exp_rv = (have_txn && mc >= t_rs) ? (t_owner ? 2'b10 : 2'b01) : 2'b00;
      check("req_ready", bus.req_ready, g);
      check("mem_en", bus.mem_en, have_txn && !t_err && (mc == t_acc + 1));
      check("mem_we", bus.mem_we, lat_we);
      check("mem_addr", bus.mem_addr, lat_addr);
      check("mem_wdata", bus.mem_wdata, lat_wdata);
      check("rsp_valid", bus.rsp_valid, exp_rv);
      if (exp_rv != 2'b00) begin
        check("rsp_rdata", bus.rsp_rdata, t_rdata);
        check("rsp_err", bus.rsp_err, t_err);
      end
      if (have_txn && !t_err && t_we && (mc == t_acc + 1)) ref_mem[t_addr] = t_wdata;
      if (g != 2'b00) begin
        p         = g[1];
        have_txn  = 1'b1;
        t_acc     = mc;
        t_owner   = p;
        t_we      = bus.req_we[p];
        t_addr    = bus.req_addr[p];
        t_wdata   = bus.req_wdata[p];
        t_err     = (t_addr[1:0] != 2'b00);
        t_rs      = mc + (t_err ? 1 : LAT + 2);
        t_rdata   = (t_err || t_we) ? 32'h0 : ref_rd(t_addr);
        last_g    = p;
        lat_we    = t_we;
        lat_addr  = t_addr;
        lat_wdata = t_wdata;
      end else if ((exp_rv != 2'b00) && bus.rsp_ready[t_owner]) begin
        have_txn = 1'b0;
      end
    end
  endtask

  initial begin
    mc = 0;
    have_txn = 1'b0;
    forever begin
      @(negedge clk);
      model_step();
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_wait();
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b11;
    repeat (8) next_cycle();
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
    if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  int gq[$];
  int gcyc[$];
  int en_cnt;
  bit rsp_seen;
  bit found;

  initial begin
    total = 0;
    bad   = 0;
    mem_store[32'h10] = 32'hDEAD_BEEF;
    ref_mem[32'h10]   = 32'hDEAD_BEEF;
    bus.req_valid = 2'b11;
    bus.req_we    = 2'b00;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 2'b00;
    reset = 1'b1;
    #1 reset = 1'b0;
    @(negedge clk);
    check("lit_rst_ready", bus.req_ready, 2'b00);
    check("lit_rst_mem_en", bus.mem_en, 1'b0);
    repeat (2) next_cycle();
    reset = 1'b1;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b11;
    next_cycle();

    // Port 1 read of 0x10, response in cycle 4.
    bus.req_valid = 2'b10; bus.req_we = 2'b00; bus.req_addr[1] = 32'h10;
    @(negedge clk); check("t1_ready", bus.req_ready, 2'b10);
    next_cycle(); bus.req_valid = 2'b00;
    @(negedge clk);
    check("t1_mem_en", bus.mem_en, 1'b1);
    check("t1_mem_addr", bus.mem_addr, 32'h10);
    check("t1_mem_we", bus.mem_we, 1'b0);
    next_cycle(); next_cycle();
    @(negedge clk); check("t1_early", bus.rsp_valid, 2'b00);
    next_cycle();
    @(negedge clk);
    check("t1_rsp_valid", bus.rsp_valid, 2'b10);
    check("t1_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
    check("t1_err", bus.rsp_err, 1'b0);
    next_cycle();

    // Both ports requesting continuously: strict alternation.
    bus.req_valid = 2'b11; bus.req_addr[0] = 32'h20; bus.req_addr[1] = 32'h24;
    for (int i = 0; i < 40 && gq.size() < 4; i++) begin
      @(negedge clk);
      if (bus.req_ready != 2'b00) begin
        gq.push_back(int'(bus.req_ready[1]));
        gcyc.push_back(i);
      end
      next_cycle();
    end
    bus.req_valid = 2'b00;
    check("rr_count", gq.size(), 4);
    if (gq.size() == 4) begin
      for (int k = 0; k < 4; k++) check("rr_grant", gq[k], k % 2);
      check("rr_interval", gcyc[1] - gcyc[0], LAT + 3);
    end
    idle_wait();

    // Port 0 write.
    bus.req_valid = 2'b01; bus.req_we = 2'b01;
    bus.req_addr[0] = 32'h8; bus.req_wdata[0] = 32'h1234_5678;
    en_cnt = 0; rsp_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.mem_en) begin
        en_cnt++;
        check("wr_mem_we", bus.mem_we, 1'b1);
        check("wr_mem_wdata", bus.mem_wdata, 32'h1234_5678);
        check("wr_mem_addr", bus.mem_addr, 32'h8);
      end
      if ((bus.rsp_valid != 2'b00) && !rsp_seen) begin
        rsp_seen = 1'b1;
        check("wr_rsp_valid", bus.rsp_valid, 2'b01);
        check("wr_rdata", bus.rsp_rdata, 32'h0);
      end
      next_cycle();
      bus.req_valid = 2'b00;
    end
    check("wr_pulses", en_cnt, 1);
    check("wr_rsp_seen", rsp_seen, 1'b1);
    check("wr_stored", store_rd(32'h8), 32'h1234_5678);
    bus.req_we = 2'b00;

    // Port 1 misaligned read: error next cycle, no memory access.
    bus.req_valid = 2'b10; bus.req_addr[1] = 32'h13;
    @(negedge clk);
    check("mis_ready", bus.req_ready, 2'b10);
    next_cycle(); bus.req_valid = 2'b00;
    @(negedge clk);
    check("mis_rsp_valid", bus.rsp_valid, 2'b10);
    check("mis_err", bus.rsp_err, 1'b1);
    check("mis_rdata", bus.rsp_rdata, 32'h0);
    check("mis_mem_en", bus.mem_en, 1'b0);
    next_cycle();
    @(negedge clk); check("mis_mem_en2", bus.mem_en, 1'b0);
    idle_wait();

    // Backpressure on port 0 while port 1 waits.
    bus.rsp_ready = 2'b10; bus.req_valid = 2'b01; bus.req_addr[0] = 32'h10;
    next_cycle();
    bus.req_valid = 2'b10; bus.req_addr[1] = 32'h30;
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.rsp_valid != 2'b00) begin
        found = 1'b1;
        break;
      end
      next_cycle();
    end
    check("bp_found", found, 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clk);
      check("bp_valid", bus.rsp_valid, 2'b01);
      check("bp_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
      check("bp_block", bus.req_ready, 2'b00);
      next_cycle();
    end
    bus.rsp_ready = 2'b11;
    @(negedge clk); check("bp_last_valid", bus.rsp_valid, 2'b01);
    next_cycle();
    @(negedge clk);
    check("bp_released", bus.rsp_valid, 2'b00);
    check("bp_next_grant", bus.req_ready, 2'b10);
    next_cycle();
    idle_wait();

    // Reset during WAIT, then a tie goes to port 0.
    bus.req_valid = 2'b01; bus.req_addr[0] = 32'h40;
    next_cycle(); bus.req_valid = 2'b00;
    @(negedge clk); check("rw_issue", bus.mem_en, 1'b1);
    next_cycle();
    reset = 1'b0; bus.req_valid = 2'b11;
    #1;
    check("rw_rsp_valid", bus.rsp_valid, 2'b00);
    check("rw_mem_en", bus.mem_en, 1'b0);
    check("rw_req_ready", bus.req_ready, 2'b00);
    check("rw_mem_addr", bus.mem_addr, 32'h0);
    next_cycle();
    reset = 1'b1;
    @(negedge clk); check("rw_first_grant", bus.req_ready, 2'b01);
    next_cycle();
    idle_wait();

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      bus.req_valid = 2'($urandom_range(0, 3));
      bus.req_we    = 2'($urandom_range(0, 3));
      for (int p = 0; p < 2; p++) begin
        bus.req_addr[p]  = rand_addr();
        bus.req_wdata[p] = $urandom();
      end
      bus.rsp_ready = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      next_cycle();
    end
    idle_wait();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
